// File: rtl/wb_reg_slave.sv
// -----------------------------------------------------------------------------
// wb_reg_slave
// Wishbone register slave that fronts a byte-level bus engine. Four 8-bit
// registers sit behind the bus: CSR (enable / interrupt enable), DPR (tx byte
// out, rx byte in), CMDR (command issue and completion status) and FSMR
// (engine state, read-only). A two-state command FSM tracks whether a
// command is outstanding in the engine.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   cyc_i, stb_i, we_i Wishbone cycle / strobe / write-enable
//   adr_i, dat_i       register select and write data
//   ack_o, dat_o       acknowledge and read data (0x00 outside ack cycles)
//   irq_o              level interrupt, raised on command completion when IE=1
//   cmd_valid_o, cmd_o one-cycle command pulse and command code to the engine
//   tx_data_o          last byte written to DPR
//   cmd_done_i         one-cycle completion pulse from the engine
//   cmd_status_i       completion status (00 done, 01 nak, 10 arb lost, 11 err)
//   rx_data_i          received byte, valid with cmd_done_i
//   fsm_state_i        engine state, visible through FSMR
// -----------------------------------------------------------------------------
module wb_reg_slave #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  irq_o,
  output logic                  cmd_valid_o,
  output logic [2:0]            cmd_o,
  output logic [7:0]            tx_data_o,
  input  logic                  cmd_done_i,
  input  logic [1:0]            cmd_status_i,
  input  logic [7:0]            rx_data_i,
  input  logic [7:0]            fsm_state_i
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_irq;
  logic                  r_cmd_valid;
  logic [2:0]            r_cmd;       // code driven to the engine
  logic [2:0]            r_cmd_fld;   // CMDR bits 2:0 as seen by software
  logic [7:0]            r_tx;
  logic [7:0]            r_rx;
  logic                  r_en;
  logic                  r_ie;
  logic                  r_don;
  logic                  r_nak;
  logic                  r_al;
  logic                  r_err;

  logic                  w_req;
  logic                  w_wr_csr;
  logic                  w_wr_dpr;
  logic                  w_wr_cmdr;
  logic                  w_rd_cmdr;
  logic                  w_busy;
  logic                  w_issue;
  logic                  w_bad_cmd;
  logic                  w_done;
  logic                  w_disable;
  logic [DATA_WIDTH-1:0] w_rd_val;

  // The !ack_o term makes a held request wait out the ack cycle, so the
  // slave can never ack on two consecutive cycles.
  assign w_req     = cyc_i & stb_i & ~r_ack;
  assign w_wr_csr  = w_req &  we_i & (adr_i == 2'd0);
  assign w_wr_dpr  = w_req &  we_i & (adr_i == 2'd1);
  assign w_wr_cmdr = w_req &  we_i & (adr_i == 2'd2);
  assign w_rd_cmdr = w_req & ~we_i & (adr_i == 2'd2);

  assign w_issue   = w_wr_cmdr & r_en & ~w_busy & (dat_i[2:0] != 3'd7);
  assign w_bad_cmd = w_wr_cmdr & r_en & ~w_busy & (dat_i[2:0] == 3'd7);
  assign w_done    = cmd_done_i & w_busy;
  assign w_disable = w_wr_csr & ~dat_i[7];

  // Command FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Command FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_issue) w_state_nxt = S_BUSY;
      S_BUSY: if (w_disable || cmd_done_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command FSM: state decode
  always_comb begin
    w_busy = (r_state == S_BUSY);
  end

  // Read mux, evaluated at the request edge so dat_o is valid in the ack cycle
  always_comb begin
    w_rd_val = '0;
    case (adr_i)
      2'd0:    w_rd_val = {r_en, r_ie, 6'b000000};
      2'd1:    w_rd_val = r_rx;
      2'd2:    w_rd_val = {r_don, r_nak, r_al, r_err, 1'b0, r_cmd_fld};
      default: w_rd_val = fsm_state_i;
    endcase
  end

  // Bus handshake and read data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req & ~we_i) ? w_rd_val : '0;
    end
  end

  // CSR and DPR
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en <= 1'b0;
      r_ie <= 1'b0;
      r_tx <= 8'h00;
      r_rx <= 8'h00;
    end else begin
      if (w_wr_csr) begin
        r_en <= dat_i[7];
        r_ie <= dat_i[6];
      end
      if (w_wr_dpr) r_tx <= dat_i;
      if (w_done && !w_disable) r_rx <= rx_data_i;
    end
  end

  // Command issue and CMDR status. Disable outranks a coincident completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= 3'd0;
      r_cmd_fld   <= 3'd0;
      {r_don, r_nak, r_al, r_err} <= 4'b1000;
    end else begin
      r_cmd_valid <= w_issue;
      if (w_issue) r_cmd <= dat_i[2:0];
      if (w_disable) begin
        {r_don, r_nak, r_al, r_err} <= 4'b1000;
      end else if (w_issue) begin
        {r_don, r_nak, r_al, r_err} <= 4'b0000;
        r_cmd_fld <= dat_i[2:0];
      end else if (w_bad_cmd) begin
        {r_don, r_nak, r_al, r_err} <= 4'b1001;
        r_cmd_fld <= 3'd7;
      end else if (w_done) begin
        r_don <= 1'b1;
        r_nak <= (cmd_status_i == 2'b01);
        r_al  <= (cmd_status_i == 2'b10);
        r_err <= (cmd_status_i == 2'b11);
      end
    end
  end

  // Interrupt: clearing IE or disabling wins, then completion, then CMDR read
  always_ff @(posedge clk_i) begin
    if (rst_i)                                  r_irq <= 1'b0;
    else if (w_wr_csr && (!dat_i[7] || !dat_i[6])) r_irq <= 1'b0;
    else if (w_done)                            r_irq <= r_ie;
    else if (w_rd_cmdr)                         r_irq <= 1'b0;
  end

  assign ack_o       = r_ack;
  assign dat_o       = r_dat;
  assign irq_o       = r_irq;
  assign cmd_valid_o = r_cmd_valid;
  assign cmd_o       = r_cmd;
  assign tx_data_o   = r_tx;

endmodule

// File: doc/wb_reg_slave.md
WB_REG_SLAVE -- requirements
Module: wb_reg_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, register address width.
REQ-002 Parameter DATA_WIDTH, default 8, data bus width; only 8 is supported.
REQ-003 clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 cyc_i  input  1  Wishbone cycle valid from master.
REQ-006 stb_i  input  1  Wishbone strobe from master.
REQ-007 we_i  input  1  1 = write, 0 = read.
REQ-008 adr_i  input  ADDR_WIDTH  register select: 0 CSR, 1 DPR, 2 CMDR, 3 FSMR.
REQ-009 dat_i  input  DATA_WIDTH  write data from master.
REQ-010 ack_o  output  1  Wishbone acknowledge.
REQ-011 dat_o  output  DATA_WIDTH  read data to master.
REQ-012 irq_o  output  1  level interrupt.
REQ-013 cmd_valid_o  output  1  one-cycle command issue pulse to the byte-level engine.
REQ-014 cmd_o  output  3  command code: 0 WAIT, 1 WRITE, 2 READ_ACK, 3 READ_NAK, 4 START, 5 STOP, 6 SET_BUS.
REQ-015 tx_data_o  output  8  last byte written to DPR.
REQ-016 cmd_done_i  input  1  one-cycle completion pulse from the engine.
REQ-017 cmd_status_i  input  2  completion status, sampled with cmd_done_i: 00 DONE, 01 NAK, 10 ARB_LOST, 11 ERROR.
REQ-018 rx_data_i  input  8  received byte, sampled with cmd_done_i.
REQ-019 fsm_state_i  input  8  engine state, readable through FSMR.

Function
REQ-020 Bus handshake: a request is cyc_i & stb_i & !ack_o sampled at edge N.
REQ-021 ack_o SHALL be 1 for exactly cycle N+1 and then return to 0.
REQ-022 A request held through the ack cycle is acked again at N+3; the slave never acks two consecutive cycles.
REQ-023 Reads: dat_o SHALL carry the register value during the ack cycle and 0x00 in all other cycles.
REQ-024 Writes: register updates take effect at edge N+1, the same edge that raises ack_o.
REQ-025 CSR (adr 0): bit7 E (enable), bit6 IE (interrupt enable), both R/W; bits5:0 read 0, writes ignored.
REQ-026 DPR (adr 1): a write loads tx_data_o; a read returns the rx byte latched at the last cmd_done_i.
REQ-027 CMDR (adr 2) read layout: bit7 DON, bit6 NAK, bit5 AL, bit4 ERR, bit3 0, bits2:0 last issued command.
REQ-028 FSMR (adr 3): read returns fsm_state_i; writes are acked and ignored.
REQ-029 Command FSM states: IDLE and BUSY.
REQ-030 IDLE -> BUSY on a CMDR write with E=1 and dat_i[2:0] <= 6: cmd_o <= dat_i[2:0]; cmd_valid_o = 1 for the ack cycle only; DON/NAK/AL/ERR cleared.
REQ-031 A CMDR write with E=1 and code 7 SHALL set ERR and DON, issue no pulse, and remain in IDLE.
REQ-032 A CMDR write in BUSY or with E=0 SHALL be acked and ignored (no pulse, no status change).
REQ-033 BUSY -> IDLE on cmd_done_i: DON=1; NAK, AL or ERR set per cmd_status_i; rx byte latched; irq_o <= IE.
REQ-034 cmd_done_i in IDLE SHALL be ignored.
REQ-035 irq_o clears at the ack of a CMDR read.
REQ-036 If cmd_done_i and the clearing CMDR read coincide, the completion wins and irq_o remains 1.
REQ-037 A CSR write with E=0 SHALL force IDLE, clear irq_o, and set CMDR status to 0x80 (last command field retained).
REQ-038 Clearing IE SHALL clear irq_o on the same edge.

Reset
REQ-039 On rst_i=1 at a rising edge: ack_o=0, dat_o=0x00, irq_o=0, cmd_valid_o=0, cmd_o=0, tx_data_o=0x00.
REQ-040 On reset: CSR=0x00, CMDR=0x80, rx byte=0x00, FSM=IDLE.
REQ-041 Reset mid-transaction drops any pending ack and any in-flight command; a later cmd_done_i is ignored.

Verification
REQ-042 Reset then read all four addresses -> 0x00, 0x00, 0x80, fsm_state_i; each ack exactly one cycle after the request.
REQ-043 Write CSR 0xC0, DPR 0x44, CMDR 0x01 -> cmd_valid_o one cycle, cmd_o=1, tx_data_o=0x44; CMDR read = 0x01 while BUSY.
REQ-044 In BUSY, pulse cmd_done_i with status 01 and rx_data_i 0xA5 -> irq_o=1; CMDR reads 0xC1 then irq_o=0; DPR reads 0xA5.
REQ-045 Second CMDR write 0x04 while BUSY -> acked, no cmd_valid_o, cmd_o stays 1.
REQ-046 CMDR write 0x07 with E=1 -> CMDR reads 0x97, no pulse.
REQ-047 cmd_done_i coincident with the CMDR read ack -> irq_o stays 1.
REQ-048 CSR write 0x00 during BUSY -> IDLE and irq_o=0; a later cmd_done_i leaves CMDR at 0x80.
